// File: rtl/washer_exec.sv
// Washing-machine control/execute stage: decodes ROM instructions and sequences timed actuator ops.
// Optional build macro: WASHER_ILLEGAL_TRAP_EN (undefined opcodes halt with illegal=1).
module washer_exec #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int START_ADDR  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   tick,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   fill_valve,
  output logic                   drain_valve,
  output logic                   motor_fwd,
  output logic                   motor_rev,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            phase,
  output logic                   illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TIMED, S_DONE} state_t;

  localparam logic [7:0] OP_HALT    = 8'h00;
  localparam logic [7:0] OP_WAIT    = 8'h11;
  localparam logic [7:0] OP_FILL    = 8'h12;
  localparam logic [7:0] OP_RELEASE = 8'h13;
  localparam logic [7:0] OP_FWD     = 8'h14;
  localparam logic [7:0] OP_REV     = 8'h15;
  localparam logic [7:0] OP_SET     = 8'h21;
  localparam logic [7:0] OP_DEC     = 8'h22;
  localparam logic [7:0] OP_J       = 8'h30;
  localparam logic [7:0] OP_JZ      = 8'h31;
  localparam logic [7:0] OP_JNZ     = 8'h32;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, pc_inc;
  logic [3:0][15:0]       regs_q, regs_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [3:0]             sel_q, sel_d;   // {fill, drain, fwd, rev} for the op in flight
  logic [3:0]             act_q, act_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   illegal_q, illegal_d;

  logic [7:0]  op;
  logic [1:0]  rsel;
  logic [15:0] imm;
  logic        timed;
  logic [3:0]  tsel;
  logic        unused_instr_bits;

  assign op   = instr[7:0];
  assign rsel = instr[9:8];
  assign imm  = instr[31:16];
  assign unused_instr_bits = ^instr[15:10];
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    regs_d    = regs_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    act_d     = act_q;
    illegal_d = illegal_q;
    timed     = 1'b0;
    tsel      = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        act_d = '0;
        if (start) begin
          pc_d      = ADDR_WIDTH'(START_ADDR);
          illegal_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        act_d = '0;
        if (!pause) begin
          case (op)
            OP_HALT:    state_d = S_DONE;
            OP_SET:     begin regs_d[rsel] = imm; pc_d = pc_inc; end
            OP_DEC:     begin regs_d[rsel] = regs_q[rsel] - 16'd1; pc_d = pc_inc; end
            OP_J:       pc_d = imm[ADDR_WIDTH-1:0];
            OP_JZ:      pc_d = (regs_q[rsel] == '0) ? imm[ADDR_WIDTH-1:0] : pc_inc;
            OP_JNZ:     pc_d = (regs_q[rsel] != '0) ? imm[ADDR_WIDTH-1:0] : pc_inc;
            OP_WAIT:    timed = 1'b1;
            OP_FILL:    begin timed = 1'b1; tsel = 4'b1000; end
            OP_RELEASE: begin timed = 1'b1; tsel = 4'b0100; end
            OP_FWD:     begin timed = 1'b1; tsel = 4'b0010; end
            OP_REV:     begin timed = 1'b1; tsel = 4'b0001; end
            default: begin
`ifdef WASHER_ILLEGAL_TRAP_EN
              state_d   = S_DONE;
              illegal_d = 1'b1;
`else
              pc_d = pc_inc;
`endif
            end
          endcase
          if (timed) begin
            if (imm == '0) begin
              pc_d = pc_inc;
            end else begin
              cnt_d   = imm;
              sel_d   = tsel;
              act_d   = tsel;
              state_d = S_TIMED;
            end
          end
        end
      end
      S_TIMED: begin
        // Actuator output is rebuilt from sel_q every cycle so a pause drops it and release restores it.
        if (pause) begin
          act_d = '0;
        end else if (tick && cnt_q == 16'd1) begin
          act_d   = '0;
          sel_d   = '0;
          cnt_d   = '0;
          pc_d    = pc_inc;
          state_d = S_RUN;
        end else begin
          act_d = sel_q;
          if (tick) cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_TIMED);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      regs_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      act_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      regs_q    <= regs_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      act_q     <= act_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc          = pc_q;
  assign fill_valve  = act_q[3];
  assign drain_valve = act_q[2];
  assign motor_fwd   = act_q[1];
  assign motor_rev   = act_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign phase       = regs_q[2];
  assign illegal     = illegal_q;

endmodule

// File: doc/washer_exec.md
Name: washer_exec

Overview:
- Control/execute stage directly downstream of the washing-machine program ROM.
- Drives `pc` into the combinational ROM and consumes the returned 32-bit instruction in the same cycle.
- Executes register, branch and timed actuator instructions.
- Drives the fill valve, drain valve and motor direction outputs, and exposes the program phase (register 2) to the panel.

Parameters:
INSTR_WIDTH, 32, instruction width; format {imm[31:16], reg[15:8], op[7:0]}
ADDR_WIDTH, 8, pc width
START_ADDR, 2, pc loaded on start

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins program from IDLE/DONE
pause  in  1  level; door open/hold, stalls execution
tick  in  1  1-cycle time-base strobe for timed ops
instr  in  INSTR_WIDTH  instruction at pc (combinational ROM)
pc  out  ADDR_WIDTH  program counter
fill_valve  out  1  water inlet
drain_valve  out  1  water outlet
motor_fwd  out  1  drum forward
motor_rev  out  1  drum reverse
busy  out  1  high in RUN/TIMED
done  out  1  high in DONE
phase  out  16  register r2
illegal  out  1  illegal-opcode trap flag (see optional feature)

Behaviour:
- Register file: 4 x 16-bit (r0..r3), selected by reg[1:0]; upper reg bits ignored. `phase` = r2.
- Reset: state IDLE, pc=0, r0..r3=0, counter=0, all actuators 0, busy=0, done=0, illegal=0.
- States: IDLE, RUN, TIMED, DONE.
- IDLE/DONE + start: pc<=START_ADDR, done<=0, illegal<=0, ->RUN. Registers keep their values.
- RUN + start: start ignored.
- RUN (and pause=0): decode instr every cycle.
  - 0x00 halt: ->DONE; pc holds.
  - 0x21 set: r[reg]<=imm; pc+1.
  - 0x22 dec: r[reg]<=r[reg]-1 mod 2^16 (0 -> 0xFFFF); pc+1.
  - 0x30 j: pc<=imm[ADDR_WIDTH-1:0].
  - 0x31 jz: branch if r[reg]==0, else pc+1.
  - 0x32 jnz: branch if r[reg]!=0, else pc+1.
  - 0x11 wait, 0x12 fill, 0x13 release, 0x14 forward, 0x15 reverse:
    - imm==0: no actuator, pc+1, stay RUN (1 cycle).
    - imm!=0: counter<=imm, assert matching actuator (wait: none), ->TIMED.
  - Other opcodes: NOP, pc+1 (unless trap enabled).
- pc increments wrap modulo 2^ADDR_WIDTH.
- TIMED:
  - Counter decrements on tick when pause=0.
  - tick with counter==1: actuators<=0, pc+1, ->RUN.
  - Actuator is high exactly from the cycle after decode through the cycle of the final tick.
- Actuators are registered and one-hot-or-zero; fill and drain are never both high, fwd and rev are never both high.
- pause=1:
  - In RUN: no decode, no state change.
  - In TIMED: ticks ignored, counter frozen, all actuators forced 0.
  - On pause release: the active actuator reasserts the following cycle (registered) and counting resumes.
- busy = RUN|TIMED; done = DONE. Both registered.
- rst mid-operation: immediately returns to reset state; actuators 0 the next cycle.

Optional Feature:
WASHER_ILLEGAL_TRAP_EN
- Defined: undefined opcode in RUN -> DONE with illegal=1, pc held at the offending address; illegal clears on start or rst.
- Undefined: undefined opcodes are NOPs (pc+1); illegal tied 0.

Test Plan:
1. Reset release then start at cycle 5 -> pc=0 with all outputs 0 before start; pc=2 and busy=1 the cycle after start.
2. fill imm=3 with tick every cycle -> fill_valve high exactly 3 cycles; pc advances by 1 the cycle after it drops; other actuators 0 throughout.
3. set r0=2; forward 1; dec r0; jnz r0 -> forward address -> motor_fwd pulses twice, then fall-through with r0=0; a further dec r0 gives r0=0xFFFF.
4. forward imm=5, pause=1 after 2 ticks for 10 cycles with ticks running -> motor_fwd 0 and counter frozen at 3 during pause; motor_fwd reasserts and 3 more ticks complete the op.
5. set r2=4 then halt -> phase=4, done=1, busy=0, pc holds; start -> pc=2, done=0.
6. wait imm=0 and opcode 0x7F -> each takes 1 cycle with no actuator; 0x7F gives pc+1 without WASHER_ILLEGAL_TRAP_EN, and DONE with illegal=1 with it defined.
